// File: rtl/theremin_pkg.sv
// Shared types and defaults for the theremin pitch-measurement blocks.
package theremin_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meter_state_e;

  localparam int GATE_CYCLES_DEFAULT = 50000;

  // A single-cycle gate still needs a one-bit counter to hold its position.
  function automatic int gate_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input followed by a
// single-cycle rising-edge detector on the synchronized level.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic sync_q1;
  logic sync_q2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= async_in;
      sync_q2 <= sync_q1;
    end
  end

  assign rise = sync_q1 & ~sync_q2;

endmodule

// File: rtl/osc_freq_meter.sv
// Counts oscillator rising edges over fixed gate windows and hands each
// window's count to a consumer over a valid/ready interface.
//   state   | meaning
//   IDLE    | gate stopped, counters held at 0, pending result kept
//   MEASURE | gate counter running, edges accumulated per window
module osc_freq_meter
  import theremin_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEFAULT,
  parameter int CNT_W       = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             osc_in,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overrun,
  output logic             saturated
);

  localparam int                GW        = gate_width(GATE_CYCLES);
  localparam logic [GW-1:0]     GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  meter_state_e     state_q;
  meter_state_e     state_d;
  logic             start;
  logic             run;
  logic             last;
  logic             rise;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             clip;
  logic             clip_next;
  logic             at_max;
  logic             handshake;

  sync_edge_det u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (osc_in),
    .rise     (rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    run     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = MEASURE;
          start   = 1'b1;
        end
      end
      MEASURE: begin
        if (!enable) begin
          state_d = IDLE;
        end else begin
          run = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // cnt_next includes an edge seen in the window's final cycle.
  assign last      = run && (gate_cnt == GATE_LAST);
  assign at_max    = (edge_cnt == CNT_MAX);
  assign cnt_next  = (rise && !at_max) ? edge_cnt + 1'b1 : edge_cnt;
  assign clip_next = clip | (rise & at_max);
  assign handshake = result_valid & result_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      clip     <= 1'b0;
    end else if (!run || last) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      clip     <= 1'b0;
    end else begin
      gate_cnt <= gate_cnt + 1'b1;
      edge_cnt <= cnt_next;
      clip     <= clip_next;
    end
  end

  // A load always wins over a handshake; overrun only when the old value
  // was neither consumed nor being consumed this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result       <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
      saturated    <= 1'b0;
    end else begin
      if (last) begin
        result       <= cnt_next;
        saturated    <= clip_next;
        result_valid <= 1'b1;
        if (result_valid && !result_ready) begin
          overrun <= 1'b1;
        end
      end else if (handshake) begin
        result_valid <= 1'b0;
      end
      if (start) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: doc/osc_freq_meter.md
OSC_FREQ_METER -- requirements
Module: osc_freq_meter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 50000, meaning clk cycles per measurement window (1 ms at 50 MHz).
REQ-002 SHALL have parameter CNT_W, default 24, meaning width of the edge count result.
REQ-003 SHALL have port clk  input  1  system clock; the block uses this single clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port enable  input  1  starts and continues measurement while high.
REQ-006 SHALL have port osc_in  input  1  asynchronous antenna oscillator square wave.
REQ-007 SHALL have port result  output  CNT_W  rising-edge count of the last completed window.
REQ-008 SHALL have port result_valid  output  1  result holds an unconsumed value.
REQ-009 SHALL have port result_ready  input  1  consumer accepts result when high with result_valid.
REQ-010 SHALL have port overrun  output  1  sticky flag: a window result was overwritten before being consumed.
REQ-011 SHALL have port saturated  output  1  the current result clipped at all-ones.

Function
REQ-012 SHALL pass osc_in through a 2-flop synchronizer; rising edge = sync_q1 & ~sync_q2.
REQ-013 SHALL implement states IDLE and MEASURE; IDLE->MEASURE when enable=1; MEASURE->IDLE when enable=0, discarding the partial window without producing a result.
REQ-014 In MEASURE, gate counter SHALL run 0..GATE_CYCLES-1, then wrap to 0 and start the next window with no dead cycle.
REQ-015 Edge counter SHALL increment once per detected edge within the window, including an edge in the window's last cycle.
REQ-016 At the window's last cycle, the final count SHALL load into result, and result_valid SHALL be 1 on the next cycle (latency 1).
REQ-017 The edge counter SHALL restart at 0, or at 1 if an edge occurs in the first cycle of the new window.
REQ-018 Edge counter SHALL saturate at 2^CNT_W-1; saturated SHALL be latched with each result.
REQ-019 Handshake: result_valid & result_ready SHALL clear result_valid next cycle; result SHALL stay stable while result_valid=1 unless overwritten.
REQ-020 If a new result loads while result_valid=1 and result_ready=0, it SHALL overwrite result, keep result_valid=1, and set overrun.
REQ-021 If a load and a handshake occur in the same cycle, the new result SHALL load, result_valid SHALL stay 1, and overrun SHALL NOT set.
REQ-022 overrun SHALL clear only on reset or on the IDLE->MEASURE transition.
REQ-023 Leaving MEASURE SHALL NOT clear a pending result_valid.

Reset
REQ-024 On rst=1, state SHALL be IDLE, all counters and synchronizer flops SHALL be 0, and result, result_valid, overrun and saturated SHALL all be 0.
REQ-025 Reset asserted mid-window SHALL abort the window immediately, with no result produced.

Structure
REQ-026 The state encoding (IDLE, MEASURE) and the default GATE_CYCLES SHALL live in a shared package, theremin_pkg.
REQ-027 The synchronizer plus edge detector SHALL be a sub-module, sync_edge_det, reusable for other async inputs.
REQ-028 The gate counter width SHALL be $clog2(GATE_CYCLES); the RTL SHALL contain no other sub-modules.

Verification (GATE_CYCLES=100, CNT_W=8, clk period 20 ns)
REQ-029 osc_in period 200 ns, enable=1, ready=1 -> result=10 each window, with valid pulsing 1 cycle per 100 clk cycles and overrun=0.
REQ-030 osc_in period 40 ns (edges near every other cycle), CNT_W=5 -> result=31 and saturated=1.
REQ-031 ready=0 for 2 windows at period 200 ns -> result=10, valid=1, overrun=1; then ready=1 -> valid=0 next cycle.
REQ-032 enable dropped at gate cycle 50 -> no valid; re-enable -> first result after 100 cycles and overrun cleared.
REQ-033 rst pulsed at gate cycle 70 with valid=1 -> all outputs 0 asynchronously; after release with enable=1 -> next result 100 cycles later.
REQ-034 Edge placed in last and first window cycle; handshake coincident with load -> edge counted in the correct window, with valid held and no overrun.
